oam_dma_ctrl: RTL and testbench

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/nes_pkg.sv | 16 +
 rtl/oam_dma_ctrl.sv | 107 ++++++++++
 tb/tb_oam_dma_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared NES bus definitions: OAM DMA state encoding and default register addresses
package nes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HALT  = 3'd2,
        ST_ALIGN = 3'd3,
        ST_READ  = 3'd4,
        ST_WRITE = 3'd5
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - OAM DMA engine: halts the CPU and copies one 256-byte page to the PPU OAM data port
module oam_dma_ctrl
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    output logic [7:0]  cpu_data_in,
    output logic        rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [7:0]  bus_data_in,
    output logic        dma_busy
);

    dma_state_t state;
    dma_state_t state_next;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] data_latch;
    logic       parity;
    logic       trigger;

    assign trigger = cpu_wen && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            page       <= 8'h00;
            index      <= 8'h00;
            data_latch <= 8'h00;
            parity     <= 1'b0;
        end else if (cyc_en) begin
            state  <= state_next;
            parity <= ~parity;
            if (state == ST_IDLE && trigger) begin
                page  <= cpu_data_out;
                index <= 8'h00;
            end
            if (state == ST_READ) begin
                data_latch <= bus_data_in;
            end
            if (state == ST_WRITE) begin
                index <= index + 8'd1;
            end
        end
    end

    // HALT decides on the parity value it is about to toggle to, hence ~parity
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (trigger) state_next = ST_WAIT;
            ST_WAIT:  if (!cpu_wen) state_next = ST_HALT;
            ST_HALT:  state_next = (~parity) ? ST_ALIGN : ST_READ;
            ST_ALIGN: state_next = ST_READ;
            ST_READ:  state_next = ST_WRITE;
            ST_WRITE: state_next = (index == 8'hFF) ? ST_IDLE : ST_READ;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Reset forces the CPU pass-through so an aborted transfer cannot leak a final OAM write
    always_comb begin
        bus_addr     = cpu_addr;
        bus_data_out = cpu_data_out;
        bus_ren      = cpu_ren;
        bus_wen      = cpu_wen;
        if (!rst) begin
            case (state)
                ST_HALT, ST_ALIGN: begin
                    bus_addr     = {page, index};
                    bus_data_out = 8'h00;
                    bus_ren      = 1'b0;
                    bus_wen      = 1'b0;
                end
                ST_READ: begin
                    bus_addr     = {page, index};
                    bus_data_out = 8'h00;
                    bus_ren      = 1'b1;
                    bus_wen      = 1'b0;
                end
                ST_WRITE: begin
                    bus_addr     = OAM_DATA_ADDR;
                    bus_data_out = data_latch;
                    bus_ren      = 1'b0;
                    bus_wen      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rdy         = (state == ST_IDLE);
    assign dma_busy    = (state != ST_IDLE);
    assign cpu_data_in = bus_data_in;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - scoreboard bench for oam_dma_ctrl: directed DMA, stall, abort and decode vectors
module tb_oam_dma_ctrl;

    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam logic [15:0] OAM_REG = 16'h2004;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wen;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc_en = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        cpu_ren = 1'b0;
    logic        cpu_wen = 1'b0;
    logic [7:0]  cpu_data_in;
    logic        rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_ren;
    logic        bus_wen;
    logic [7:0]  bus_data_in;
    logic        dma_busy;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_cyc = 0;
    int   rdy_low_cnt = 0;
    int   oam_wr_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    assign bus_data_in = mem_byte(bus_addr);

    always @(posedge clk) begin
        if (rst) n_cyc <= 0;
        else if (cyc_en) n_cyc <= n_cyc + 1;
    end

    oam_dma_ctrl #(
        .DMA_REG_ADDR (DMA_REG),
        .OAM_DATA_ADDR(OAM_REG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cyc_en      (cyc_en),
        .cpu_addr    (cpu_addr),
        .cpu_data_out(cpu_data_out),
        .cpu_ren     (cpu_ren),
        .cpu_wen     (cpu_wen),
        .cpu_data_in (cpu_data_in),
        .rdy         (rdy),
        .bus_addr    (bus_addr),
        .bus_data_out(bus_data_out),
        .bus_ren     (bus_ren),
        .bus_wen     (bus_wen),
        .bus_data_in (bus_data_in),
        .dma_busy    (dma_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor_loop();
        txn_t e;
        forever begin
            @(negedge clk);
            if (!rst && cyc_en) begin
                if (!rdy) rdy_low_cnt++;
                if (bus_ren || bus_wen) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_bus_op: addr %h ren %b wen %b, none expected", bus_addr, bus_ren, bus_wen);
                    end else begin
                        e = exp_q.pop_front();
                        check("bus_addr", 32'(bus_addr), 32'(e.addr));
                        check("bus_wen", 32'(bus_wen), 32'(e.wen));
                        if (e.wen) check("bus_data_out", 32'(bus_data_out), 32'(e.data));
                        else check("cpu_data_in", 32'(cpu_data_in), 32'(mem_byte(e.addr)));
                    end
                    if (bus_wen && bus_addr == OAM_REG) oam_wr_cnt++;
                end
            end
        end
    endtask

    task automatic tick(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
        @(posedge clk);
        #1;
        cpu_addr = a;
        cpu_data_out = d;
        cpu_ren = r;
        cpu_wen = w;
        cyc_en = 1'b1;
    endtask

    task automatic tick_idle();
        tick(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d, input logic w);
        txn_t t;
        t.addr = a;
        t.data = d;
        t.wen = w;
        exp_q.push_back(t);
    endtask

    task automatic push_page(input logic [7:0] page, input int count);
        for (int i = 0; i < count; i++) begin
            push({page, 8'(i)}, 8'h00, 1'b0);
            push(OAM_REG, mem_byte({page, 8'(i)}), 1'b1);
        end
    endtask

    task automatic run_dma(input logic [7:0] page, input int extra, input int want_align, input bit stall);
        int base;
        int align_exp;
        int guard;
        bit stalled;
        if (((n_cyc + extra + 4) & 1) != want_align) tick_idle();
        base = rdy_low_cnt;
        tick(DMA_REG, page, 1'b0, 1'b1);
        push(DMA_REG, page, 1'b1);
        for (int k = 0; k < extra; k++) begin
            tick(16'h0300 + 16'(k), 8'hA0 + 8'(k), 1'b0, 1'b1);
            push(16'h0300 + 16'(k), 8'hA0 + 8'(k), 1'b1);
            check("wait_rdy_low", 32'(rdy), 32'd0);
            check("wait_busy", 32'(dma_busy), 32'd1);
        end
        tick_idle();
        align_exp = (n_cyc + 2) & 1;
        push_page(page, 256);
        stalled = 1'b0;
        guard = 0;
        do begin
            tick_idle();
            guard++;
            if (stall && !stalled && bus_ren && !rdy && bus_addr[7:0] == 8'h05) begin
                stalled = 1'b1;
                cyc_en = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check("stall_bus_addr", 32'(bus_addr), 32'({page, 8'h05}));
                    check("stall_bus_ren", 32'(bus_ren), 32'd1);
                end
            end
        end while (dma_busy && guard < 1200);
        check("dma_done_in_budget", 32'(dma_busy), 32'd0);
        check("rdy_after_dma", 32'(rdy), 32'd1);
        check("halt_to_idle_cycles", 32'(rdy_low_cnt - base - (extra + 1)), 32'(513 + align_exp));
        if (stall) check("stall_happened", 32'(stalled), 32'd1);
        tick_idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_abort(input logic [7:0] page);
        int base_wr;
        int guard;
        tick(DMA_REG, page, 1'b0, 1'b1);
        push(DMA_REG, page, 1'b1);
        tick_idle();
        push_page(page, 100);
        base_wr = oam_wr_cnt;
        guard = 0;
        while (oam_wr_cnt - base_wr < 100 && guard < 400) begin
            tick_idle();
            guard++;
        end
        check("abort_reached_100", 32'(oam_wr_cnt - base_wr), 32'd100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rdy", 32'(rdy), 32'd1);
        check("abort_busy", 32'(dma_busy), 32'd0);
        rst = 1'b0;
        repeat (20) tick_idle();
        check("abort_oam_writes", 32'(oam_wr_cnt - base_wr), 32'd100);
        check("abort_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        rst = 1'b1;
        cpu_addr = 16'h1234;
        cpu_data_out = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy", 32'(rdy), 32'd1);
        check("reset_busy", 32'(dma_busy), 32'd0);
        check("reset_passthru_addr", 32'(bus_addr), 32'h1234);
        check("reset_passthru_data", 32'(bus_data_out), 32'h5A);
        rst = 1'b0;
        tick_idle();

        tick(DMA_REG, 8'h07, 1'b1, 1'b0);
        push(DMA_REG, 8'h00, 1'b0);
        tick(16'h4015, 8'h07, 1'b0, 1'b1);
        push(16'h4015, 8'h07, 1'b1);
        check("read_4014_no_dma", 32'(dma_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick_idle();
            check("no_dma_busy", 32'(dma_busy), 32'd0);
            check("no_dma_rdy", 32'(rdy), 32'd1);
        end

        run_dma(8'h02, 0, 0, 1'b0);
        run_dma(8'h02, 0, 1, 1'b0);
        run_dma(8'hFF, 2, 0, 1'b0);
        run_dma(8'h00, 0, 1, 1'b1);
        run_abort(8'h10);

        tick_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
